// File: rtl/ecp5pll_phase_ctrl.sv
// rtl/ecp5pll_phase_ctrl.sv - EHXPLLL dynamic phase-shift sequencer
// Tracks per-channel phase in 1/8-VCO steps and emits shortest-path step trains.
module ecp5pll_phase_ctrl #(
    parameter int channels     = 4,
    parameter int phase_bits   = 10,
    parameter int div0         = 5,
    parameter int div1         = 5,
    parameter int div2         = 5,
    parameter int div3         = 5,
    parameter int init0        = 0,
    parameter int init1        = 0,
    parameter int init2        = 0,
    parameter int init3        = 0,
    parameter int setup_cycles = 2,
    parameter int pulse_cycles = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_ch,
    input  logic                  req_rel,
    input  logic [phase_bits-1:0] req_phase,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    input  logic [1:0]            rd_ch,
    output logic [phase_bits-1:0] rd_phase,
    output logic [1:0]            phasesel,
    output logic                  phasedir,
    output logic                  phasestep,
    output logic                  phaseloadreg
);

    localparam int PW = phase_bits + 1;
    localparam logic [2:0]            CH_LIM   = 3'(channels);
    localparam logic [15:0]           SETUP_LD = 16'(setup_cycles - 1);
    localparam logic [15:0]           PULSE_LD = 16'(pulse_cycles - 1);
    localparam logic [phase_bits-1:0] MOST_NEG = {1'b1, {(phase_bits-1){1'b0}}};
    localparam logic [phase_bits-1:0] ONE_P    = phase_bits'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    function automatic logic [phase_bits:0] mod_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return PW'(8 * div0);
            2'd1:    return PW'(8 * div1);
            2'd2:    return PW'(8 * div2);
            default: return PW'(8 * div3);
        endcase
    endfunction

    function automatic logic [phase_bits-1:0] init_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return phase_bits'(init0);
            2'd1:    return phase_bits'(init1);
            2'd2:    return phase_bits'(init2);
            default: return phase_bits'(init3);
        endcase
    endfunction

    state_t                state;
    logic [15:0]           cnt;
    logic [phase_bits:0]   steps_left;
    logic [phase_bits-1:0] phase [4];

    logic [phase_bits:0]   ev_m;
    logic [phase_bits:0]   ev_cur;
    logic [phase_bits:0]   ev_tgt;
    logic [phase_bits:0]   ev_d;
    logic [phase_bits:0]   ev_mag;
    logic [phase_bits:0]   ev_steps;
    logic                  ev_dir;
    logic                  ev_err;
    logic [phase_bits-1:0] neg_phase;
    logic [phase_bits:0]   sel_m;
    logic [phase_bits-1:0] sel_max;
    logic [phase_bits-1:0] sel_cur;

    assign req_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign phaseloadreg = 1'b0;
    assign rd_phase     = ({1'b0, rd_ch} >= CH_LIM) ? '0 : phase[rd_ch];

    // Request evaluation against the live count of the addressed channel.
    always_comb begin
        ev_m      = mod_of(req_ch);
        ev_cur    = {1'b0, phase[req_ch]};
        ev_tgt    = {1'b0, req_phase};
        neg_phase = ~req_phase + ONE_P;
        ev_d      = '0;
        ev_mag    = '0;
        ev_steps  = '0;
        ev_dir    = 1'b0;
        ev_err    = 1'b0;
        if (req_rel) begin
            ev_dir   = req_phase[phase_bits-1];
            ev_mag   = ev_dir ? {1'b0, neg_phase} : {1'b0, req_phase};
            ev_steps = ev_mag;
            ev_err   = (req_phase == MOST_NEG) || (ev_mag >= ev_m);
        end else begin
            ev_err = (ev_tgt >= ev_m);
            ev_d   = (ev_tgt >= ev_cur) ? (ev_tgt - ev_cur) : (ev_tgt + ev_m - ev_cur);
            if (ev_d <= (ev_m >> 1)) begin
                ev_dir   = 1'b0;
                ev_steps = ev_d;
            end else begin
                ev_dir   = 1'b1;
                ev_steps = ev_m - ev_d;
            end
        end
        if ({1'b0, req_ch} >= CH_LIM) begin
            ev_err = 1'b1;
        end
    end

    always_comb begin
        sel_m   = mod_of(phasesel) - PW'(1);
        sel_max = sel_m[phase_bits-1:0];
        sel_cur = phase[phasesel];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            steps_left <= '0;
            phasesel   <= 2'd0;
            phasedir   <= 1'b0;
            phasestep  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                phase[i] <= init_of(2'(i));
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req_valid) begin
                        phasesel   <= req_ch;
                        phasedir   <= ev_dir;
                        steps_left <= ev_steps;
                        if (ev_err || (ev_steps == '0)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= ev_err;
                        end else begin
                            state <= S_SETUP;
                            cnt   <= SETUP_LD;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state     <= S_HI;
                        phasestep <= 1'b1;
                        cnt       <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_HI: begin
                    if (cnt == '0) begin
                        state      <= S_LO;
                        phasestep  <= 1'b0;
                        cnt        <= PULSE_LD;
                        steps_left <= steps_left - PW'(1);
                        // Count follows the falling edge of each step, wrapping at M.
                        if (phasedir) begin
                            phase[phasesel] <= (sel_cur == '0) ? sel_max : (sel_cur - ONE_P);
                        end else begin
                            phase[phasesel] <= (sel_cur == sel_max) ? '0 : (sel_cur + ONE_P);
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_LO: begin
                    if (cnt == '0) begin
                        if (steps_left != '0) begin
                            state     <= S_HI;
                            phasestep <= 1'b1;
                            cnt       <= PULSE_LD;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    phasestep <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// tb/tb_ecp5pll_phase_ctrl.sv - randomized check of the phase sequencer against a modulo-arithmetic model
module tb_ecp5pll_phase_ctrl;

    localparam int SETUP = 2;
    localparam int PULSE = 2;

    logic       clk_i = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_ch = 2'd0;
    logic       req_rel = 1'b0;
    logic [9:0] req_phase = 10'd0;
    logic       done;
    logic       err;
    logic       busy;
    logic [1:0] rd_ch = 2'd0;
    logic [9:0] rd_phase;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       phaseloadreg;

    int n_checks = 0;
    int n_errors = 0;
    int mods [4] = '{40, 32, 24, 40};
    int inits[4] = '{0, 7, 1, 0};
    int ph   [4];

    ecp5pll_phase_ctrl #(
        .channels(3), .phase_bits(10),
        .div0(5), .div1(4), .div2(3), .div3(5),
        .init0(0), .init1(7), .init2(1), .init3(0),
        .setup_cycles(SETUP), .pulse_cycles(PULSE)
    ) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_rel(req_rel), .req_phase(req_phase),
        .done(done), .err(err), .busy(busy),
        .rd_ch(rd_ch), .rd_phase(rd_phase),
        .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_counts();
        for (int c = 0; c < 3; c++) begin
            rd_ch = 2'(c);
            #1;
            check($sformatf("rd_phase[%0d]", c), int'(rd_phase), ph[c]);
        end
    endtask

    task automatic run_req(input int ch, input bit rel, input logic [9:0] val);
        int  m, cur, dlt, d, steps, lat, hi, bad, w;
        bit  dir, e;
        m = mods[ch]; cur = ph[ch]; dir = 0; steps = 0; e = 0;
        if (ch >= 3) begin
            e = 1;
        end else if (rel) begin
            dlt = (val >= 512) ? int'(val) - 1024 : int'(val);
            if (val == 10'h200 || (dlt < 0 ? -dlt : dlt) >= m) e = 1;
            else begin dir = (dlt < 0); steps = dir ? -dlt : dlt; end
        end else begin
            if (int'(val) >= m) e = 1;
            else begin
                d = ((int'(val) - cur) % m + m) % m;
                if (d <= m / 2) begin dir = 0; steps = d; end
                else begin dir = 1; steps = m - d; end
            end
        end
        w = 0;
        @(negedge clk_i);
        while (!req_ready && w < 300) begin @(negedge clk_i); w++; end
        check("ready_before_req", int'(req_ready), 1);
        req_ch = 2'(ch); req_rel = rel; req_phase = val; req_valid = 1'b1;
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        check("phasesel", int'(phasesel), ch);
        if (!e) check("phasedir", int'(phasedir), int'(dir));
        lat = 0; hi = 0; bad = 0;
        while (!done && lat < 2000) begin
            if (phasestep) hi++;
            if (req_ready || !busy) bad++;
            @(posedge clk_i); #1;
            lat++;
        end
        check("done_seen", int'(done), 1);
        check("done_latency", lat, (e || steps == 0) ? 0 : SETUP + 2 * PULSE * steps);
        check("step_high_cycles", hi, PULSE * steps);
        check("err", int'(err), int'(e));
        check("busy_while_active", bad, 0);
        if (!e) ph[ch] = ((cur + (dir ? -steps : steps)) % m + m) % m;
        @(posedge clk_i); #1;
        check("idle_after_done", int'(busy), 0);
        check_counts();
    endtask

    initial begin
        int rises, w, ch, dv;
        bit prev, rel;
        logic [9:0] val;
        for (int c = 0; c < 4; c++) ph[c] = inits[c];

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_phasestep", int'(phasestep), 0);
        check("rst_phasedir", int'(phasedir), 0);
        check("rst_phasesel", int'(phasesel), 0);
        check("rst_loadreg", int'(phaseloadreg), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(req_ready), 1);
        check_counts();
        @(negedge clk_i) reset_n = 1'b1;

        run_req(1, 0, 10'd3);
        run_req(0, 0, 10'd35);
        run_req(0, 0, 10'd15);
        run_req(2, 1, 10'h3fd);
        run_req(2, 1, 10'd0);
        run_req(0, 0, 10'd40);
        run_req(3, 0, 10'd1);
        run_req(1, 0, 10'd32);
        run_req(1, 1, 10'h200);
        run_req(0, 1, 10'd40);
        run_req(2, 1, 10'h3e8);
        run_req(1, 0, 10'(ph[1]));

        // Reset while the second step pulse is high.
        @(negedge clk_i);
        req_ch = 2'd0; req_rel = 1'b1; req_phase = 10'd5; req_valid = 1'b1;
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        rises = 0; prev = 0; w = 0;
        while (rises < 2 && w < 200) begin
            @(posedge clk_i); #1;
            if (phasestep && !prev) rises++;
            prev = phasestep;
            w++;
        end
        check("second_hi_reached", rises, 2);
        @(negedge clk_i) reset_n = 1'b0;
        @(posedge clk_i); #1;
        check("abort_phasestep", int'(phasestep), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(req_ready), 1);
        for (int c = 0; c < 4; c++) ph[c] = inits[c];
        check_counts();
        @(negedge clk_i) reset_n = 1'b1;
        run_req(0, 1, 10'd4);

        for (int i = 0; i < 40; i++) begin
            ch  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            rel = 1'($urandom_range(0, 1));
            if (rel) begin
                dv  = $urandom_range(0, 2 * mods[ch] + 4) - (mods[ch] + 2);
                val = ($urandom_range(0, 15) == 0) ? 10'h200 : 10'(dv);
            end else begin
                val = 10'($urandom_range(0, mods[ch] + 2));
            end
            run_req(ch, rel, val);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
